// File: rtl/spi_slave_fifo.sv
// spi_slave_fifo: SPI slave endpoint with a clocked shift engine, runtime
// SPI mode / bit order, and TX/RX word FIFOs with valid/ready handshakes.
// Optional macro SPI_SLAVE_SYNC_EN adds a 2-flop synchroniser on sclk, cs_n
// and mosi ahead of the edge detector (pin-to-detect latency 4 clk vs 2 clk).
module spi_slave_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cpol,
    input  logic                          cpha,
    input  logic                          lsb_first,
    input  logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [DATA_WIDTH-1:0]         rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    input  logic                          sclk,
    input  logic                          cs_n,
    input  logic                          mosi,
    output logic                          miso,
    output logic                          miso_oe,
    output logic                          busy,
    output logic                          tx_underrun,
    output logic                          rx_overflow
);

    localparam int W  = DATA_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(DATA_WIDTH);

    logic sclk_in, cs_in, mosi_in;

`ifdef SPI_SLAVE_SYNC_EN
    logic [1:0] sclk_sy, cs_sy, mosi_sy;

    // Two-flop synchronisers for asynchronous SPI pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sy <= '0;
            cs_sy   <= '0;
            mosi_sy <= '0;
        end else begin
            sclk_sy <= {sclk_sy[0], sclk};
            cs_sy   <= {cs_sy[0], cs_n};
            mosi_sy <= {mosi_sy[0], mosi};
        end
    end

    assign sclk_in = sclk_sy[1];
    assign cs_in   = cs_sy[1];
    assign mosi_in = mosi_sy[1];
`else
    assign sclk_in = sclk;
    assign cs_in   = cs_n;
    assign mosi_in = mosi;
`endif

    // Pin history. cs history resets low so a cs_n held low across reset is
    // not mistaken for a fresh frame start; only a real fall restarts.
    logic [1:0] sclk_h, cs_h;
    logic       mosi_h;

    // Two-deep history used for edge detection; mosi aligned with sclk_h[0]
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_h <= '0;
            cs_h   <= '0;
            mosi_h <= 1'b0;
        end else begin
            sclk_h <= {sclk_h[0], sclk_in};
            cs_h   <= {cs_h[0], cs_in};
            mosi_h <= mosi_in;
        end
    end

    // Frame / engine state
    logic          cpol_l, cpha_l, lsb_l;
    logic [CW-1:0] bit_cnt;
    logic          reload;
    logic [W-1:0]  tx_sr, rx_sr;

    // FIFO state
    logic [W-1:0]  tx_mem [FIFO_DEPTH];
    logic [W-1:0]  rx_mem [FIFO_DEPTH];
    logic [PW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
    logic [LW-1:0] tx_cnt, rx_cnt;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic [W-1:0]  tx_head;

    logic cs_fall, cs_rise, lead, trail;
    logic sample_edge, shift_edge, load, word_done;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic [W-1:0] rx_next;

    assign cs_fall = cs_h[1] & ~cs_h[0];
    assign cs_rise = ~cs_h[1] & cs_h[0];
    assign lead    = (sclk_h[1] == cpol_l) & (sclk_h[0] != cpol_l);
    assign trail   = (sclk_h[1] != cpol_l) & (sclk_h[0] == cpol_l);

    assign sample_edge = busy & ~cs_fall & ~cs_rise & (cpha_l ? trail : lead);
    assign shift_edge  = busy & ~cs_fall & ~cs_rise & (cpha_l ? lead : trail);
    assign word_done   = sample_edge & (bit_cnt == CW'(W - 1));
    assign load        = cs_fall | (shift_edge & reload);

    assign rx_next = lsb_l ? {mosi_h, rx_sr[W-1:1]} : {rx_sr[W-2:0], mosi_h};

    assign tx_full  = (tx_cnt == LW'(FIFO_DEPTH));
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == LW'(FIFO_DEPTH));
    assign rx_empty = (rx_cnt == '0);
    assign tx_head  = tx_empty ? '0 : tx_mem[tx_rd];

    assign tx_push = tx_valid & ~tx_full;
    assign tx_pop  = load & ~tx_empty;
    assign rx_push = word_done & ~rx_full;
    assign rx_pop  = rx_ready & ~rx_empty;

    assign tx_ready = ~tx_full;
    assign rx_valid = ~rx_empty;
    assign rx_data  = rx_empty ? '0 : rx_mem[rx_rd];
    assign tx_level = tx_cnt;
    assign rx_level = rx_cnt;

    assign miso    = busy & (lsb_l ? tx_sr[0] : tx_sr[W-1]);
    assign miso_oe = busy;

    // Shift engine: frame start/end, sampling into RX, shifting/reloading TX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpol_l  <= 1'b0;
            cpha_l  <= 1'b0;
            lsb_l   <= 1'b0;
            busy    <= 1'b0;
            bit_cnt <= '0;
            reload  <= 1'b0;
            tx_sr   <= '0;
            rx_sr   <= '0;
        end else if (cs_fall) begin
            cpol_l  <= cpol;
            cpha_l  <= cpha;
            lsb_l   <= lsb_first;
            busy    <= 1'b1;
            bit_cnt <= '0;
            reload  <= 1'b0;
            tx_sr   <= tx_head;
            rx_sr   <= '0;
        end else if (cs_rise && busy) begin
            // partial RX word and the loaded TX word are both dropped
            busy    <= 1'b0;
            bit_cnt <= '0;
            reload  <= 1'b0;
            tx_sr   <= '0;
            rx_sr   <= '0;
        end else if (sample_edge) begin
            rx_sr <= rx_next;
            if (word_done) begin
                bit_cnt <= '0;
                reload  <= 1'b1;
            end else begin
                bit_cnt <= bit_cnt + CW'(1);
            end
        end else if (shift_edge) begin
            if (reload) begin
                tx_sr  <= tx_head;
                reload <= 1'b0;
            end else if (bit_cnt == '0 && cpha_l) begin
                // first leading edge of a cpha=1 word: bit already on miso
                tx_sr <= tx_sr;
            end else if (lsb_l) begin
                tx_sr <= {1'b0, tx_sr[W-1:1]};
            end else begin
                tx_sr <= {tx_sr[W-2:0], 1'b0};
            end
        end
    end

    // One-cycle error pulses for failed TX loads and dropped RX words
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_underrun <= 1'b0;
            rx_overflow <= 1'b0;
        end else begin
            tx_underrun <= load & tx_empty;
            rx_overflow <= word_done & rx_full;
        end
    end

    // TX FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr  <= '0;
            tx_rd  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + PW'(1);
            if (tx_pop)  tx_rd <= tx_rd + PW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + LW'(1);
                2'b01:   tx_cnt <= tx_cnt - LW'(1);
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    // RX FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wr  <= '0;
            rx_rd  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push) rx_wr <= rx_wr + PW'(1);
            if (rx_pop)  rx_rd <= rx_rd + PW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + LW'(1);
                2'b01:   rx_cnt <= rx_cnt - LW'(1);
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until written (reads gated by count)
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr] <= tx_data;
        if (rx_push) rx_mem[rx_wr] <= rx_next;
    end

endmodule

// File: tb/tb_spi_slave_fifo.sv
// tb_spi_slave_fifo: directed + randomized bench for spi_slave_fifo. A bus
// functional SPI master drives the pins; a queue-based model predicts FIFO
// contents, miso words and error pulse counts.
module tb_spi_slave_fifo;

    localparam int W = 32;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpol, cpha, lsb_first;
    logic [W-1:0] tx_data;
    logic         tx_valid, tx_ready;
    logic [W-1:0] rx_data;
    logic         rx_valid, rx_ready;
    logic [2:0]   tx_level, rx_level;
    logic         sclk, cs_n, mosi, miso, miso_oe, busy;
    logic         tx_underrun, rx_overflow;

    spi_slave_fifo #(.DATA_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_level(tx_level), .rx_level(rx_level),
        .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
        .busy(busy), .tx_underrun(tx_underrun), .rx_overflow(rx_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int und_cnt = 0, ovf_cnt = 0;
    int exp_und = 0, exp_ovf = 0;

    logic [W-1:0] tx_model [$];
    logic [W-1:0] rx_model [$];
    logic [W-1:0] m_tx [$];
    logic [W-1:0] m_rx [$];

    // pulse counters (each pulse is one clk wide, so cycles == events)
    always @(negedge clk) begin
        if (tx_underrun === 1'b1) und_cnt++;
        if (rx_overflow === 1'b1) ovf_cnt++;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic half();
        repeat (4) @(negedge clk);
    endtask

    // rx_valid must rise exactly one clk after the final sample edge is seen
    task automatic rxv_chk();
        @(negedge clk); check("rx_valid_before", rx_valid, 1'b0);
        @(negedge clk); check("rx_valid_after", rx_valid, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    // SPI master: one chip-select frame of nbits, sending m_tx, collecting m_rx
    task automatic frame(input bit pol, input bit pha, input bit lsb, input int nbits, input bit tchk);
        logic [W-1:0] cur_tx, cur_rx;
        int b, idx;
        cur_tx = '0;
        cur_rx = '0;
        m_rx.delete();
        cpol = pol; cpha = pha; lsb_first = lsb; sclk = pol; mosi = 1'b0;
        repeat (3) @(negedge clk);
        cs_n = 1'b0;
        @(negedge clk);
        if (tchk) check("busy_lat1", busy, 1'b0);
        @(negedge clk);
        if (tchk) begin
            check("busy_lat2", busy, 1'b1);
            check("miso_oe", miso_oe, 1'b1);
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            b = i % W;
            idx = lsb ? b : W - 1 - b;
            if (b == 0) begin
                cur_tx = (m_tx.size() > 0) ? m_tx.pop_front() : '0;
                cur_rx = '0;
            end
            if (!pha) begin
                mosi = cur_tx[idx];
                half();
                cur_rx[idx] = miso;
                sclk = ~pol;
                if (tchk && i == W - 1) rxv_chk(); else half();
                sclk = pol;
            end else begin
                sclk = ~pol;
                mosi = cur_tx[idx];
                half();
                cur_rx[idx] = miso;
                sclk = pol;
                if (tchk && i == W - 1) rxv_chk(); else half();
            end
            if (b == W - 1) m_rx.push_back(cur_rx);
        end
        half();
        cs_n = 1'b1;
        half();
        check("busy_end", busy, 1'b0);
        check("miso_idle", miso, 1'b0);
    endtask

    // Model: frame start loads one word; every completed word asks for a
    // reload at its next shift edge (cpha=0: its closing trailing edge,
    // cpha=1: the next bit's leading edge, which exists only if bits follow).
    task automatic run_frame(input bit pol, input bit pha, input bit lsb, input int nbits, input bit tchk);
        logic [W-1:0] sent [$];
        logic [W-1:0] exp_m [$];
        int k, loads;
        sent = m_tx;
        k = nbits / W;
        loads = pha ? 1 + (nbits - 1) / W : 1 + nbits / W;
        for (int j = 0; j < loads; j++) begin
            if (tx_model.size() > 0) exp_m.push_back(tx_model.pop_front());
            else begin exp_m.push_back('0); exp_und++; end
        end
        for (int j = 0; j < k; j++) begin
            if (rx_model.size() < D) rx_model.push_back(sent[j]);
            else exp_ovf++;
        end
        frame(pol, pha, lsb, nbits, tchk);
        check("miso_word_count", m_rx.size(), k);
        for (int j = 0; j < k && j < m_rx.size(); j++) check("miso_word", m_rx[j], exp_m[j]);
        check("underrun_pulses", und_cnt, exp_und);
        check("overflow_pulses", ovf_cnt, exp_ovf);
        check("tx_level", tx_level, tx_model.size());
        check("rx_level", rx_level, rx_model.size());
    endtask

    task automatic push_tx(input logic [W-1:0] w);
        check("tx_ready", tx_ready, (tx_model.size() < D) ? 1'b1 : 1'b0);
        tx_data = w;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        if (tx_model.size() < D) tx_model.push_back(w);
    endtask

    task automatic pop_rx();
        if (rx_model.size() == 0) begin
            check("rx_valid_empty", rx_valid, 1'b0);
        end else begin
            check("rx_valid", rx_valid, 1'b1);
            check("rx_data", rx_data, rx_model.pop_front());
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
        end
    endtask

    task automatic reset_values(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_miso"}, miso, 1'b0);
        check({tag, "_miso_oe"}, miso_oe, 1'b0);
        check({tag, "_rx_valid"}, rx_valid, 1'b0);
        check({tag, "_tx_ready"}, tx_ready, 1'b1);
        check({tag, "_levels"}, {tx_level, rx_level}, 6'd0);
        check({tag, "_rx_data"}, rx_data, '0);
        check({tag, "_errs"}, {tx_underrun, rx_overflow}, 2'b00);
    endtask

    // mode table entries: {lsb_first, cpol, cpha}
    logic [2:0] modes [6];
    bit  r_pol, r_pha, r_lsb;
    int  nw, part, npush, keep;

    initial begin
        modes[0] = 3'b000; modes[1] = 3'b001; modes[2] = 3'b010;
        modes[3] = 3'b011; modes[4] = 3'b100; modes[5] = 3'b111;
        rst = 1'b1; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
        tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0;
        sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        repeat (3) @(negedge clk);
        reset_values("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        reset_values("post_reset");

        // same words in every mode and bit order
        for (int m = 0; m < 6; m++) begin
            push_tx(32'hA5A5_0F0F);
            m_tx.delete();
            m_tx.push_back(32'h1234_5678);
            run_frame(modes[m][1], modes[m][0], modes[m][2], W, 1'b1);
            pop_rx();
        end

        // three words, TX holds two: third miso word zero, one underrun
        push_tx(32'hDEAD_BEEF);
        push_tx(32'h0BAD_F00D);
        m_tx = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        run_frame(1'b1, 1'b1, 1'b0, 3 * W, 1'b0);
        repeat (3) pop_rx();

        // fifth word into a full RX FIFO is dropped
        for (int j = 0; j < 4; j++) push_tx($urandom);
        m_tx.delete();
        for (int j = 0; j < 5; j++) m_tx.push_back($urandom);
        run_frame(1'b0, 1'b0, 1'b0, 5 * W, 1'b0);
        check("rx_level_full", rx_level, 3'd4);
        repeat (4) pop_rx();

        // frame aborted after 13 bits, next frame uses the following TX word
        push_tx(32'hCAFE_0001);
        push_tx(32'hCAFE_0002);
        m_tx = '{32'h5555_AAAA};
        run_frame(1'b0, 1'b0, 1'b0, 13, 1'b0);
        pop_rx();
        m_tx = '{32'h0F1E_2D3C};
        run_frame(1'b0, 1'b0, 1'b0, W, 1'b0);
        pop_rx();

        // reset in the middle of a word
        push_tx(32'h7777_1234);
        cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; sclk = 1'b0;
        repeat (3) @(negedge clk);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            mosi = 1'($urandom_range(0, 1));
            half(); sclk = 1'b1; half(); sclk = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        reset_values("mid_reset");
        tx_model.delete();
        rx_model.delete();
        @(negedge clk);
        cs_n = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        push_tx(32'h89AB_CDEF);
        m_tx = '{32'hFEDC_BA98};
        run_frame(1'b0, 1'b0, 1'b0, W, 1'b0);
        pop_rx();

        // randomized frames: mode, bit order, word count, partial tail, TX fill
        for (int it = 0; it < 6; it++) begin
            r_pol = 1'($urandom_range(0, 1));
            r_pha = 1'($urandom_range(0, 1));
            r_lsb = 1'($urandom_range(0, 1));
            nw = $urandom_range(1, 3);
            part = ($urandom_range(0, 2) == 0) ? $urandom_range(1, W - 1) : 0;
            npush = $urandom_range(0, D - tx_model.size());
            for (int j = 0; j < npush; j++) push_tx($urandom);
            m_tx.delete();
            for (int j = 0; j < nw + ((part != 0) ? 1 : 0); j++) m_tx.push_back($urandom);
            run_frame(r_pol, r_pha, r_lsb, nw * W + part, 1'b0);
            keep = $urandom_range(0, 2);
            while (rx_model.size() > keep) pop_rx();
        end
        while (rx_model.size() > 0) pop_rx();
        pop_rx();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
